// File: rtl/mipi_csi_pkg.sv
// Shared CSI-2 / D-PHY constants and types for the lane transmitter and receiver.
package mipi_csi_pkg;

    typedef enum logic [2:0] {
        ST_STOP,
        ST_HS_RQST,
        ST_LP00,
        ST_SYNC,
        ST_HDR,
        ST_PAYLOAD,
        ST_CRC,
        ST_DRAIN
    } lane_state_t;

    // LP line encodings as {lp_p, lp_n}
    localparam logic [1:0] LP11 = 2'b11;
    localparam logic [1:0] LP01 = 2'b01;
    localparam logic [1:0] LP00 = 2'b00;

    localparam logic [7:0] SYNC_BYTE   = 8'hB8;
    localparam logic [5:0] DI_LONG_MIN = 6'h10;

    // Data types at or above the threshold carry a payload and CRC
    function automatic logic is_long(input logic [5:0] dt);
        return dt >= DI_LONG_MIN;
    endfunction

endpackage

// File: rtl/mipi_dphy_rx_lane_if.sv
// Lane-side pins and decoded packet stream of one D-PHY receive lane.
interface mipi_dphy_rx_lane_if;
    logic        lp_p;
    logic        lp_n;
    logic [7:0]  hs_byte_raw;
    logic        hs_term_en;
    logic        hdr_valid;
    logic [7:0]  di;
    logic [15:0] wc;
    logic [7:0]  ecc;
    logic        data_valid;
    logic [7:0]  data;
    logic        pkt_end;
    logic [15:0] crc_rx;
    logic        sync_err;
    logic        pkt_abort;

    modport master (
        output lp_p, lp_n, hs_byte_raw,
        input  hs_term_en, hdr_valid, di, wc, ecc, data_valid, data,
               pkt_end, crc_rx, sync_err, pkt_abort
    );

    modport slave (
        input  lp_p, lp_n, hs_byte_raw,
        output hs_term_en, hdr_valid, di, wc, ecc, data_valid, data,
               pkt_end, crc_rx, sync_err, pkt_abort
    );
endinterface

// File: rtl/mipi_lp_filter.sv
// Synchronizes the LP pin pair and accepts a new line state only after it holds steady.
module mipi_lp_filter #(
    parameter int unsigned LP_FILT = 4
) (
    input  logic       byteclk,
    input  logic       areset,
    input  logic       lp_p,
    input  logic       lp_n,
    output logic [1:0] lp_state
);
    localparam int unsigned CW = $clog2(LP_FILT + 1);

    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    cand;
    logic [CW-1:0] cnt;

    always_ff @(posedge byteclk or posedge areset) begin
        if (areset) begin
            sync1    <= '0;
            sync2    <= '0;
            cand     <= '0;
            cnt      <= '0;
            lp_state <= '0;
        end else begin
            sync1 <= {lp_p, lp_n};
            sync2 <= sync1;
            if (sync2 != cand) begin
                cand <= sync2;
                cnt  <= CW'(1);
            end else if (cnt != CW'(LP_FILT)) begin
                cnt <= cnt + CW'(1);
            end
            if (cnt == CW'(LP_FILT)) begin
                lp_state <= cand;
            end
        end
    end
endmodule

// File: rtl/mipi_dphy_rx_lane.sv
// Single-lane D-PHY/CSI-2 receiver: LP sequencing, HS bit alignment on the sync byte,
// header parse and payload/CRC streaming.
module mipi_dphy_rx_lane #(
    parameter int unsigned LP_FILT      = 4,
    parameter int unsigned LP00_MIN     = 2,
    parameter int unsigned SYNC_TIMEOUT = 64,
    parameter logic [7:0]  SYNC_BYTE    = mipi_csi_pkg::SYNC_BYTE
) (
    input  logic                byteclk,
    input  logic                areset,
    mipi_dphy_rx_lane_if.slave  bus
);
    import mipi_csi_pkg::*;

    localparam int unsigned TW = $clog2(SYNC_TIMEOUT + 1);
    localparam int unsigned MW = $clog2(LP00_MIN + 1);

    lane_state_t   state;
    logic [1:0]    lp_state;
    logic [7:0]    prev_raw;
    logic [2:0]    off;
    logic [TW-1:0] tcnt;
    logic [MW-1:0] lcnt;
    logic [1:0]    bcnt;
    logic [15:0]   pcnt;
    logic [23:0]   hdr_sh;
    logic [7:0]    crc_lo;

    logic [15:0]   win_c;
    logic [7:0]    aligned_c;
    logic          sync_hit_c;
    logic [2:0]    sync_off_c;
    logic [15:0]   hdr_wc_c;
    logic          abort_c;

    mipi_lp_filter #(.LP_FILT(LP_FILT)) u_lp_filter (
        .byteclk  (byteclk),
        .areset   (areset),
        .lp_p     (bus.lp_p),
        .lp_n     (bus.lp_n),
        .lp_state (lp_state)
    );

    assign win_c     = {bus.hs_byte_raw, prev_raw};
    assign aligned_c = win_c[off +: 8];
    assign hdr_wc_c  = hdr_sh[23:8];
    assign abort_c   = (lp_state == LP11) &&
                       (state inside {ST_SYNC, ST_HDR, ST_PAYLOAD, ST_CRC});

    // Descending scan so the lowest matching offset is the one left standing
    always_comb begin
        sync_hit_c = 1'b0;
        sync_off_c = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (win_c[k +: 8] == SYNC_BYTE) begin
                sync_hit_c = 1'b1;
                sync_off_c = 3'(k);
            end
        end
    end

    always_ff @(posedge byteclk or posedge areset) begin
        if (areset) begin
            state          <= ST_STOP;
            prev_raw       <= '0;
            off            <= '0;
            tcnt           <= '0;
            lcnt           <= '0;
            bcnt           <= '0;
            pcnt           <= '0;
            hdr_sh         <= '0;
            crc_lo         <= '0;
            bus.hs_term_en <= 1'b0;
            bus.hdr_valid  <= 1'b0;
            bus.di         <= '0;
            bus.wc         <= '0;
            bus.ecc        <= '0;
            bus.data_valid <= 1'b0;
            bus.data       <= '0;
            bus.pkt_end    <= 1'b0;
            bus.crc_rx     <= '0;
            bus.sync_err   <= 1'b0;
            bus.pkt_abort  <= 1'b0;
        end else begin
            prev_raw       <= bus.hs_byte_raw;
            bus.hdr_valid  <= 1'b0;
            bus.data_valid <= 1'b0;
            bus.pkt_end    <= 1'b0;
            bus.sync_err   <= 1'b0;
            bus.pkt_abort  <= 1'b0;

            if (abort_c) begin
                bus.pkt_abort  <= 1'b1;
                bus.hs_term_en <= 1'b0;
                state          <= ST_STOP;
            end else begin
                case (state)
                    ST_STOP: begin
                        bus.hs_term_en <= 1'b0;
                        off            <= '0;
                        if (lp_state == LP01) state <= ST_HS_RQST;
                    end
                    ST_HS_RQST: begin
                        if (lp_state == LP00) begin
                            lcnt  <= '0;
                            state <= ST_LP00;
                        end else if (lp_state == LP11) begin
                            state <= ST_STOP;
                        end
                    end
                    ST_LP00: begin
                        if (lp_state == LP11) begin
                            state <= ST_STOP;
                        end else if (lp_state == LP00) begin
                            if (lcnt == MW'(LP00_MIN - 1)) begin
                                bus.hs_term_en <= 1'b1;
                                tcnt           <= '0;
                                state          <= ST_SYNC;
                            end else begin
                                lcnt <= lcnt + MW'(1);
                            end
                        end
                    end
                    ST_SYNC: begin
                        if (sync_hit_c) begin
                            off   <= sync_off_c;
                            bcnt  <= '0;
                            state <= ST_HDR;
                        end else if (tcnt == TW'(SYNC_TIMEOUT - 1)) begin
                            bus.sync_err <= 1'b1;
                            state        <= ST_DRAIN;
                        end else begin
                            tcnt <= tcnt + TW'(1);
                        end
                    end
                    ST_HDR: begin
                        bcnt <= bcnt + 2'd1;
                        if (bcnt != 2'd3) begin
                            hdr_sh <= {aligned_c, hdr_sh[23:8]};
                        end else begin
                            bus.hdr_valid <= 1'b1;
                            bus.di        <= hdr_sh[7:0];
                            bus.wc        <= hdr_wc_c;
                            bus.ecc       <= aligned_c;
                            if (!is_long(hdr_sh[5:0])) begin
                                bus.pkt_end <= 1'b1;
                                state       <= ST_DRAIN;
                            end else if (hdr_wc_c == 16'd0) begin
                                state <= ST_CRC;
                            end else begin
                                pcnt  <= hdr_wc_c;
                                state <= ST_PAYLOAD;
                            end
                        end
                    end
                    ST_PAYLOAD: begin
                        bus.data_valid <= 1'b1;
                        bus.data       <= aligned_c;
                        pcnt           <= pcnt - 16'd1;
                        if (pcnt == 16'd1) begin
                            bcnt  <= '0;
                            state <= ST_CRC;
                        end
                    end
                    ST_CRC: begin
                        if (bcnt == 2'd0) begin
                            crc_lo <= aligned_c;
                            bcnt   <= 2'd1;
                        end else begin
                            bus.crc_rx  <= {aligned_c, crc_lo};
                            bus.pkt_end <= 1'b1;
                            state       <= ST_DRAIN;
                        end
                    end
                    ST_DRAIN: begin
                        if (lp_state == LP11) begin
                            bus.hs_term_en <= 1'b0;
                            state          <= ST_STOP;
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mipi_dphy_rx_lane.sv
// Directed bench for the D-PHY receive lane: aligned/shifted bursts, short packet,
// sync timeout, mid-payload abort and reset mid-header.
module tb_mipi_dphy_rx_lane;
    import mipi_csi_pkg::*;

    localparam int ABORT_TRIG = 92;

    logic byteclk = 1'b0;
    logic areset;

    mipi_dphy_rx_lane_if bus ();

    mipi_dphy_rx_lane #(
        .LP_FILT      (4),
        .LP00_MIN     (2),
        .SYNC_TIMEOUT (64),
        .SYNC_BYTE    (8'hB8)
    ) dut (
        .byteclk (byteclk),
        .areset  (areset),
        .bus     (bus.slave)
    );

    always #5 byteclk = ~byteclk;

    int err_cnt = 0;
    int chk_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Output monitor, sampled on the falling edge
    int cyc = 0, hv_cnt = 0, dv_cnt = 0, pe_cnt = 0, se_cnt = 0, ab_cnt = 0, both_cnt = 0;
    int se_cyc = 0, rise_cyc = 0;
    logic term_q = 1'b0;
    logic [7:0]  m_di = '0, m_ecc = '0;
    logic [15:0] m_wc = '0, m_crc = '0;
    logic [7:0]  dq[$];

    initial begin
        forever begin
            @(negedge byteclk);
            cyc++;
            if (bus.hdr_valid) begin
                hv_cnt++;
                m_di  = bus.di;
                m_wc  = bus.wc;
                m_ecc = bus.ecc;
            end
            if (bus.data_valid) begin
                dv_cnt++;
                dq.push_back(bus.data);
            end
            if (bus.pkt_end) begin
                pe_cnt++;
                m_crc = bus.crc_rx;
            end
            if (bus.hdr_valid && bus.pkt_end) both_cnt++;
            if (bus.sync_err) begin
                se_cnt++;
                se_cyc = cyc;
            end
            if (bus.pkt_abort) ab_cnt++;
            if (bus.hs_term_en && !term_q) rise_cyc = cyc;
            term_q = bus.hs_term_en;
        end
    end

    int hv0, dv0, pe0, se0, ab0, both0, q0;
    logic end_term;

    task automatic snap();
        hv0 = hv_cnt; dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
        ab0 = ab_cnt; both0 = both_cnt; q0 = dq.size();
    endtask

    task automatic drive(input logic [1:0] lp, input logic [7:0] raw);
        @(posedge byteclk);
        #1;
        bus.lp_p        = lp[1];
        bus.lp_n        = lp[0];
        bus.hs_byte_raw = raw;
    endtask

    task automatic idle(input logic [1:0] lp, input int n);
        repeat (n) drive(lp, 8'h00);
    endtask

    task automatic check_rst_outputs(input string nm);
        check({nm, "_term"}, 32'(bus.hs_term_en), 32'h0);
        check({nm, "_hdr"}, {bus.di, bus.wc, bus.ecc}, 32'h0);
        check({nm, "_pulses"}, {19'h0, bus.hdr_valid, bus.data_valid, bus.pkt_end,
                                bus.sync_err, bus.pkt_abort, bus.data}, 32'h0);
        check({nm, "_crc"}, 32'(bus.crc_rx), 32'h0);
    endtask

    // LP entry sequence, then the packet bytes serialized LSB first after n_pre zero
    // bytes and shift extra zero bits, then LP-11 exit
    task automatic play(input logic [7:0] pkt[$], input int shift, input int n_pre,
                        input bit do_abort, input int rst_at);
        bit         bq[$];
        logic [7:0] raw;
        logic [7:0] t;
        logic [1:0] lp;
        int         dv_base;
        int         nraw;
        bit         done;
        dv_base = dv_cnt;
        done    = 1'b0;
        idle(LP11, 10);
        idle(LP01, 20);
        idle(LP00, 5);
        for (int i = 0; i < n_pre * 8 + shift; i++) bq.push_back(1'b0);
        foreach (pkt[i]) begin
            t = pkt[i];
            for (int b = 0; b < 8; b++) bq.push_back(t[b]);
        end
        for (int i = 0; i < 32; i++) bq.push_back(1'b0);
        while (bq.size() % 8 != 0) bq.push_back(1'b0);
        nraw = bq.size() / 8;
        lp   = LP00;
        for (int j = 0; j < nraw && !done; j++) begin
            for (int b = 0; b < 8; b++) raw[b] = bq.pop_front();
            @(posedge byteclk);
            #1;
            if (j == rst_at) begin
                areset = 1'b1;
                #1;
                check_rst_outputs("midrst");
                repeat (2) @(posedge byteclk);
                #1;
                areset = 1'b0;
                done   = 1'b1;
            end else begin
                if (do_abort && (dv_cnt - dv_base) >= ABORT_TRIG) lp = LP11;
                bus.lp_p        = lp[1];
                bus.lp_n        = lp[0];
                bus.hs_byte_raw = raw;
            end
        end
        end_term = bus.hs_term_en;
        idle(LP11, 12);
    endtask

    task automatic check_pkt_a(input string nm);
        logic [7:0] exp_d [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hA3};
        logic [31:0] got;
        check({nm, "_hv"}, 32'(hv_cnt - hv0), 32'd1);
        check({nm, "_di"}, 32'(m_di), 32'h2A);
        check({nm, "_wc"}, 32'(m_wc), 32'h0004);
        check({nm, "_ecc"}, 32'(m_ecc), 32'h3F);
        check({nm, "_dvcnt"}, 32'(dv_cnt - dv0), 32'd4);
        for (int i = 0; i < 4; i++) begin
            got = (dq.size() > q0 + i) ? 32'(dq[q0 + i]) : 32'hDEAD;
            check($sformatf("%s_data%0d", nm, i), got, 32'(exp_d[i]));
        end
        check({nm, "_pe"}, 32'(pe_cnt - pe0), 32'd1);
        check({nm, "_crc"}, 32'(m_crc), 32'h0123);
        check({nm, "_both"}, 32'(both_cnt - both0), 32'd0);
        check({nm, "_abort"}, 32'(ab_cnt - ab0), 32'd0);
        check({nm, "_serr"}, 32'(se_cnt - se0), 32'd0);
        check({nm, "_term_mid"}, 32'(end_term), 32'd1);
        check({nm, "_term_end"}, 32'(bus.hs_term_en), 32'd0);
    endtask

    logic [7:0] pkt_a_arr [11] = '{8'hB8, 8'h2A, 8'h04, 8'h00, 8'h3F,
                                   8'hAA, 8'hBB, 8'hCC, 8'hA3, 8'h23, 8'h01};
    logic [7:0] pkt_s_arr [5]  = '{8'hB8, 8'h00, 8'h01, 8'h00, 8'h07};
    logic [7:0] pkt_a[$];
    logic [7:0] pkt_s[$];
    logic [7:0] pkt_l[$];
    logic [7:0] pkt_none[$];

    initial begin
        int shifts [4] = '{0, 3, 5, 7};
        foreach (pkt_a_arr[i]) pkt_a.push_back(pkt_a_arr[i]);
        foreach (pkt_s_arr[i]) pkt_s.push_back(pkt_s_arr[i]);
        pkt_l.push_back(8'hB8); pkt_l.push_back(8'h2A); pkt_l.push_back(8'h00);
        pkt_l.push_back(8'h01); pkt_l.push_back(8'h3F);
        for (int i = 0; i < 256; i++) pkt_l.push_back(8'(i));
        pkt_l.push_back(8'h34); pkt_l.push_back(8'h12);

        areset          = 1'b1;
        bus.lp_p        = 1'b1;
        bus.lp_n        = 1'b1;
        bus.hs_byte_raw = 8'h00;
        repeat (3) @(posedge byteclk);
        #1;
        check_rst_outputs("por");
        areset = 1'b0;
        idle(LP11, 8);

        // Same burst at several bit offsets
        foreach (shifts[s]) begin
            snap();
            play(pkt_a, shifts[s], 16, 1'b0, -1);
            check_pkt_a($sformatf("sh%0d", shifts[s]));
        end

        // Short packet: header and end together, no payload
        snap();
        play(pkt_s, 0, 16, 1'b0, -1);
        check("short_hv", 32'(hv_cnt - hv0), 32'd1);
        check("short_both", 32'(both_cnt - both0), 32'd1);
        check("short_pe", 32'(pe_cnt - pe0), 32'd1);
        check("short_dv", 32'(dv_cnt - dv0), 32'd0);
        check("short_di", 32'(m_di), 32'h00);
        check("short_wc", 32'(m_wc), 32'h0001);
        check("short_term_end", 32'(bus.hs_term_en), 32'd0);

        // No sync byte at all
        snap();
        play(pkt_none, 0, 100, 1'b0, -1);
        check("tmo_serr", 32'(se_cnt - se0), 32'd1);
        check("tmo_delay", 32'(se_cyc - rise_cyc), 32'd64);
        check("tmo_hv", 32'(hv_cnt - hv0), 32'd0);
        check("tmo_term_mid", 32'(end_term), 32'd1);
        check("tmo_term_end", 32'(bus.hs_term_en), 32'd0);

        // LP-11 in the middle of a 256-byte payload
        snap();
        play(pkt_l, 0, 16, 1'b1, -1);
        check("abt_hv", 32'(hv_cnt - hv0), 32'd1);
        check("abt_wc", 32'(m_wc), 32'h0100);
        check("abt_abort", 32'(ab_cnt - ab0), 32'd1);
        check("abt_dvcnt", 32'(dv_cnt - dv0), 32'd100);
        check("abt_pe", 32'(pe_cnt - pe0), 32'd0);
        check("abt_first", (dq.size() > q0) ? 32'(dq[q0]) : 32'hDEAD, 32'h00);
        check("abt_last", (dq.size() > q0 + 99) ? 32'(dq[q0 + 99]) : 32'hDEAD, 32'd99);
        check("abt_term_mid", 32'(end_term), 32'd0);

        // Reset mid-header drops the packet; next burst decodes cleanly
        snap();
        play(pkt_a, 0, 16, 1'b0, 19);
        check("rst_hv", 32'(hv_cnt - hv0), 32'd0);
        check("rst_pe", 32'(pe_cnt - pe0), 32'd0);
        check("rst_abort", 32'(ab_cnt - ab0), 32'd0);
        snap();
        play(pkt_a, 2, 16, 1'b0, -1);
        check_pkt_a("post_rst");

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mipi_dphy_rx_lane.md
Name: mipi_dphy_rx_lane

Overview:
- Single-lane MIPI D-PHY/CSI-2 receive path. It is the far end of our BLVDS D-PHY transmitter and lets the board loop back and check its own transmit stream.
- Tracks the LP line state (LP-11 → LP-01 → LP-00).
- Enables HS termination, then bit-aligns the deserialized HS byte stream on the 0xB8 sync byte.
- Parses the CSI-2 packet header and streams the payload and CRC bytes to the downstream checker.
- Sits behind an external 1:8 deserializer, in the byteclk domain.

Parameters:
- LP_FILT, 4, consecutive byteclk samples an LP state must hold before it is accepted (1..15).
- LP00_MIN, 2, accepted LP-00 cycles required before HS termination is enabled.
- SYNC_TIMEOUT, 64, HS bytes allowed after termination enable without a 0xB8 match.
- SYNC_BYTE, 8'hB8, leader byte.

Ports:
- byteclk  in  1  byte clock; all logic is on its rising edge
- areset  in  1  asynchronous, active-high reset
- lp_p  in  1  asynchronous LP single-ended, P line
- lp_n  in  1  asynchronous LP single-ended, N line
- hs_byte_raw  in  8  unaligned deserializer byte; bit0 is the earliest received bit
- hs_term_en  out  1  HS termination / receiver enable
- hdr_valid  out  1  one-cycle pulse; di, wc and ecc are valid
- di  out  8  data identifier
- wc  out  16  word count (little endian on the wire)
- ecc  out  8  header ECC byte, passed raw and not checked
- data_valid  out  1  payload byte strobe
- data  out  8  aligned payload byte
- pkt_end  out  1  one-cycle pulse; crc_rx is valid (long packet) or the header is done (short packet)
- crc_rx  out  16  received CRC, little endian
- sync_err  out  1  one-cycle pulse on sync timeout
- pkt_abort  out  1  one-cycle pulse when LP-11 arrives before the packet completes

Behaviour:
- Reset: all outputs are 0. State is STOP. Alignment offset, counters and synchronizers are cleared. Reset mid-packet drops the packet and emits no pulses.
- LP input conditioning:
  - lp_p and lp_n each pass through a 2-flop synchronizer.
  - lp_state updates only when the synchronized pair has been stable for LP_FILT cycles.
  - The decision therefore lags the pins by 2+LP_FILT cycles.
- Alignment window: win = {hs_byte_raw, prev_raw}, 16 bits. The byte at offset k is win[k+7:k], for k = 0..7.
- States:
  - STOP: hs_term_en=0. Go to HS_RQST when lp_state=LP-01.
  - HS_RQST: go to LP00 on LP-00. Go to STOP on LP-11. Any other state holds.
  - LP00: count accepted LP-00 cycles. When count reaches LP00_MIN, set hs_term_en=1, clear the timeout counter and go to SYNC. LP-11 returns to STOP.
  - SYNC:
    - Search all 8 offsets each cycle; the lowest matching k wins and is latched.
    - Next state is HDR with byte counter 0. The byte after the sync is the first header byte.
    - If the timeout counter reaches SYNC_TIMEOUT: pulse sync_err, go to DRAIN.
  - HDR: capture 4 aligned bytes, in order DI, WC_L, WC_H, ECC. In the cycle after the 4th byte, pulse hdr_valid with di, wc and ecc stable; they hold until the next hdr_valid.
    - Short packet (DI[5:0] < 6'h10): pulse pkt_end with hdr_valid and go to DRAIN.
    - Long packet with WC=0: go directly to CRC.
    - Otherwise: go to PAYLOAD.
  - PAYLOAD: data_valid=1 for exactly WC consecutive cycles; data is the aligned byte registered with 1 cycle latency. A 16-bit down-counter is used; WC=16'hFFFF is legal. Then go to CRC.
  - CRC: capture 2 bytes, low then high. Pulse pkt_end in the following cycle with crc_rx valid, then go to DRAIN.
  - DRAIN: ignore HS bytes (trail). On LP-11, clear hs_term_en and go to STOP.
- LP-11 accepted in SYNC, HDR, PAYLOAD or CRC:
  - pulse pkt_abort;
  - stop data_valid in that same cycle;
  - clear hs_term_en;
  - go to STOP.
  - No pkt_end follows.
- The alignment offset is relatched on every new burst and never carried over.
- At most one of hdr_valid, pkt_end, sync_err and pkt_abort pulses per cycle, except hdr_valid+pkt_end together for short packets.
- LP-10 or an illegal sequence (e.g. LP-00 straight from STOP) is ignored; the block stays in STOP.

Decomposition:
- Package mipi_csi_pkg holds:
  - the state enum (STOP, HS_RQST, LP00, SYNC, HDR, PAYLOAD, CRC, DRAIN);
  - LP encodings LP11=2'b11, LP01=2'b01, LP00=2'b00;
  - SYNC_BYTE;
  - the short/long DI threshold 6'h10.
  - The transmitter shares these constants.
- One sub-module, mipi_lp_filter: 2-flop synchronizer plus stability counter, outputting a registered lp_state[1:0].

Test Plan:
- LP-11 → LP-01 (20 cycles) → LP-00 (5 cycles) → HS with 0xB8 at offset 0, header 2A,04,00,xx, payload AA,BB,CC,A3, CRC 23,01, then LP-11 → hdr_valid with di=8'h2A, wc=4; 4 data_valid bytes AA,BB,CC,A3; pkt_end with crc_rx=16'h0123; hs_term_en low after the LP filter.
- Same burst with the stream shifted by each of 3, 5 and 7 bits → identical outputs for every offset.
- Short packet DI=8'h00, WC=16'h0001 → hdr_valid and pkt_end in the same cycle; no data_valid.
- No 0xB8 within 64 bytes after hs_term_en → sync_err pulse at byte 64; hs_term_en drops only after LP-11.
- LP-11 asserted mid-payload (byte 100 of 256) → pkt_abort; data_valid count exactly 100; no pkt_end.
- areset pulsed mid-header → all outputs 0 immediately; the next clean burst decodes correctly.
